// File: rtl/conv_layer_stream_if.sv
// Pixel-in / result-out stream bundle for conv_layer_stream.
// The slave side is the convolution layer, and the master side is the upstream/downstream logic.
interface conv_layer_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_iv;
  logic signed [DATA_WIDTH-1:0] in_id;
  logic                         in_ready_o;
  logic                         out_ov;
  logic signed [DATA_WIDTH-1:0] out_od;
  logic                         out_last_o;

  modport master (output in_iv, in_id, input in_ready_o, out_ov, out_od, out_last_o);
  modport slave  (input in_iv, in_id, output in_ready_o, out_ov, out_od, out_last_o);
endinterface

// File: rtl/conv_layer_stream.sv
// Streaming KxK valid-window convolution with line buffers, runtime weights,
// bias, rounding requantisation, optional ReLU and saturation.
module conv_layer_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int K          = 3,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                                      clk,
  input  logic                                      nrst,
  input  logic                                      w_load_iv,
  input  logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0]  w_addr_id,
  input  logic signed [DATA_WIDTH-1:0]              w_data_id,
  input  logic signed [ACC_WIDTH-1:0]               bias_id,
  input  logic                                      cfg_relu_i,
  input  logic [4:0]                                cfg_shift_i,
  conv_layer_stream_if.slave                        s_if,
  output logic                                      busy_o
);
  localparam int NW = K * K;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int EW = ACC_WIDTH + 32;
  localparam logic signed [EW-1:0] MAX_V = EW'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [EW-1:0] MIN_V = EW'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                       state_r, state_s;
  logic                         drain_cnt_r;
  logic [RW-1:0]                row_r;
  logic [CW-1:0]                col_r;
  logic signed [DATA_WIDTH-1:0] w_r      [NW];
  logic signed [DATA_WIDTH-1:0] win_r    [NW];
  logic signed [DATA_WIDTH-1:0] col_in_s [K];
  logic signed [2*DATA_WIDTH-1:0] prod_s [NW];
  logic signed [ACC_WIDTH-1:0]  bias_r, sum_s, s1_sum_r;
  logic                         relu_r;
  logic [4:0]                   shift_r;
  logic                         accept_s, last_pix_s, win_ok_s;
  logic                         win_v_r, win_last_r, s1_v_r, s1_last_r;
  logic                         out_ov_r, out_last_r;
  logic signed [DATA_WIDTH-1:0] out_od_r;

  // Round-half-up arithmetic shift, optional ReLU, then clamp to the output range.
  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [4:0]                  sh,
    input logic                        relu
  );
    logic signed [EW-1:0] t;
    logic signed [EW-1:0] rnd;
    logic signed [DATA_WIDTH-1:0] res;
    t   = EW'(acc);
    rnd = {{(EW-1){1'b0}}, 1'b1};
    if (sh != 5'd0) begin
      rnd = rnd << (sh - 5'd1);
      t   = (t + rnd) >>> sh;
    end else begin
      t = t;
    end
    if (relu && t[EW-1]) begin
      t = '0;
    end else begin
      t = t;
    end
    if (t > MAX_V) begin
      res = MAX_V[DATA_WIDTH-1:0];
    end else if (t < MIN_V) begin
      res = MIN_V[DATA_WIDTH-1:0];
    end else begin
      res = t[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  assign s_if.in_ready_o = (state_r != ST_DRAIN) && !w_load_iv;
  assign accept_s        = s_if.in_iv && s_if.in_ready_o;
  assign last_pix_s      = (row_r == RW'(ROW_NUM - 1)) && (col_r == CW'(COL_NUM - 1));
  assign win_ok_s        = (row_r >= RW'(K - 1)) && (col_r >= CW'(K - 1));
  assign busy_o          = (state_r != ST_IDLE);
  assign s_if.out_ov     = out_ov_r;
  assign s_if.out_od     = out_od_r;
  assign s_if.out_last_o = out_last_r;

  // State register and the two-cycle drain timer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = last_pix_s ? ST_DRAIN : ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_pix_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Weights load only while idle; frame config is captured with the first pixel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NW; i++) w_r[i] <= '0;
      bias_r  <= '0;
      relu_r  <= 1'b0;
      shift_r <= 5'd0;
    end else begin
      if (state_r == ST_IDLE && w_load_iv && ({1'b0, w_addr_id} < (AW+1)'(NW))) begin
        w_r[w_addr_id] <= w_data_id;
      end
      if (state_r == ST_IDLE && accept_s) begin
        bias_r  <= bias_id;
        relu_r  <= cfg_relu_i;
        shift_r <= cfg_shift_i;
      end
    end
  end

  // Raster position counters, window shift register and window-valid tags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_r      <= '0;
      col_r      <= '0;
      for (int i = 0; i < NW; i++) win_r[i] <= '0;
      win_v_r    <= 1'b0;
      win_last_r <= 1'b0;
    end else begin
      win_v_r    <= accept_s && win_ok_s;
      win_last_r <= accept_s && last_pix_s;
      if (accept_s) begin
        if (col_r == CW'(COL_NUM - 1)) begin
          col_r <= '0;
          row_r <= (row_r == RW'(ROW_NUM - 1)) ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) win_r[i*K + j] <= win_r[i*K + j + 1];
          win_r[i*K + K - 1] <= col_in_s[i];
        end
      end
    end
  end

  // Row i of lb_r holds the row that is K-1-i rows above the incoming pixel.
  if (K > 1) begin : g_lb
    logic signed [DATA_WIDTH-1:0] lb_r [K-1][COL_NUM];

    // Push the incoming pixel into its column, moving older rows up.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int i = 0; i < K - 1; i++)
          for (int j = 0; j < COL_NUM; j++) lb_r[i][j] <= '0;
      end else if (accept_s) begin
        for (int i = 0; i < K - 2; i++) lb_r[i][col_r] <= lb_r[i+1][col_r];
        lb_r[K-2][col_r] <= s_if.in_id;
      end
    end

    // New window column: buffered rows on top, live pixel at the bottom.
    always_comb begin
      for (int i = 0; i < K - 1; i++) col_in_s[i] = lb_r[i][col_r];
      col_in_s[K-1] = s_if.in_id;
    end
  end else begin : g_nolb
    // K=1 takes the pixel straight into the single window cell.
    always_comb begin
      col_in_s[0] = s_if.in_id;
    end
  end

  // Stage 1 products and adder tree.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NW; i++) begin
      prod_s[i] = w_r[i] * win_r[i];
      sum_s     = sum_s + ACC_WIDTH'(prod_s[i]);
    end
  end

  // Two pipeline stages: sum register, then bias/requant into the output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_v_r     <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sum_r   <= '0;
      out_ov_r   <= 1'b0;
      out_last_r <= 1'b0;
      out_od_r   <= '0;
    end else begin
      s1_v_r     <= win_v_r;
      s1_last_r  <= win_last_r;
      out_ov_r   <= s1_v_r;
      out_last_r <= s1_v_r && s1_last_r;
      if (win_v_r) s1_sum_r <= sum_s;
      if (s1_v_r) out_od_r <= requant(s1_sum_r + bias_r, shift_r, relu_r);
    end
  end
endmodule

// File: tb/tb_conv_layer_stream.sv
// Self-checking bench for conv_layer_stream (8x8 grid, 3x3 kernel): scoreboard of
// expected results pushed on pixel acceptance, plus a table of constant-frame vectors.
module tb_conv_layer_stream;
  logic              clk = 1'b0;
  logic              nrst;
  logic              w_load_iv;
  logic [3:0]        w_addr_id;
  logic signed [7:0] w_data_id;
  logic signed [23:0] bias_id;
  logic              cfg_relu_i;
  logic [4:0]        cfg_shift_i;
  logic              busy_o;

  conv_layer_stream_if #(.DATA_WIDTH(8)) bus();

  conv_layer_stream #(.DATA_WIDTH(8), .ROW_NUM(8), .COL_NUM(8), .K(3), .ACC_WIDTH(24)) dut (
    .clk(clk), .nrst(nrst), .w_load_iv(w_load_iv), .w_addr_id(w_addr_id),
    .w_data_id(w_data_id), .bias_id(bias_id), .cfg_relu_i(cfg_relu_i),
    .cfg_shift_i(cfg_shift_i), .s_if(bus), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { int v; bit last; int cyc; } exp_t;
  typedef struct { int pix; int wt; int bias; int shift; int relu; int expv; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nvec = 0, nfail = 0, cyc = 0;
  int   wm[9];
  int   img[64];
  int   bias_g = 0, shift_g = 0, relu_g = 0;
  bit   use_model = 1'b1;
  int   exp_const = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int model(input int r, input int c);
    int a = bias_g;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) a += wm[i*3 + j] * img[(r - 2 + i)*8 + (c - 2 + j)];
    if (shift_g > 0) a = (a + (1 << (shift_g - 1))) >>> shift_g;
    if (relu_g != 0 && a < 0) a = 0;
    if (a > 127) a = 127;
    else if (a < -128) a = -128;
    return a;
  endfunction

  // Output monitor: every result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst && bus.out_ov) begin
      nvec++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_out: got value %0d with no result outstanding", bus.out_od);
      end else begin
        mon_e = sb.pop_front();
        if (int'(bus.out_od) !== mon_e.v || bus.out_last_o !== mon_e.last || (cyc - mon_e.cyc) != 2) begin
          nfail++;
          $display("FAIL result: got val %0d last %0b latency %0d, expected val %0d last %0b latency 2",
                   bus.out_od, bus.out_last_o, cyc - mon_e.cyc, mon_e.v, mon_e.last);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_w(input int wv[9]);
    for (int i = 0; i < 9; i++) begin
      w_load_iv = 1'b1; w_addr_id = 4'(i); w_data_id = 8'(wv[i]);
      wm[i] = wv[i];
      @(posedge clk); #1;
    end
    w_load_iv = 1'b0;
  endtask

  task automatic send_pixel(input int v, input int r, input int c, input int gap);
    bit acc = 1'b0;
    int tries = 0;
    bus.in_iv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_iv = 1'b1; bus.in_id = 8'(v);
    while (!acc && tries < 50) begin
      @(negedge clk); acc = bus.in_ready_o;
      @(posedge clk); #1;
      tries++;
    end
    bus.in_iv = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    else if (r >= 2 && c >= 2) sb.push_back('{use_model ? model(r, c) : exp_const, (r == 7 && c == 7), cyc});
  endtask

  task automatic run_frame(input bit gaps, input int pulse_at, input int abort_at);
    int n;
    bias_id = 24'(bias_g); cfg_shift_i = 5'(shift_g); cfg_relu_i = (relu_g != 0);
    for (int p = 0; p < 64; p++) begin
      if (p == abort_at) begin
        nrst = 1'b0; #1;
        chk("rst_ready", bus.in_ready_o, 1);
        chk("rst_ov", bus.out_ov, 0);
        chk("rst_od", bus.out_od, 0);
        chk("rst_last", bus.out_last_o, 0);
        chk("rst_busy", busy_o, 0);
        sb.delete();
        for (int i = 0; i < 9; i++) wm[i] = 0;
        repeat (2) begin @(posedge clk); #1; end
        nrst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        return;
      end
      if (p == pulse_at) begin
        w_load_iv = 1'b1; w_addr_id = 4'd4; w_data_id = -8'sd7;
        bus.in_iv = 1'b1; bus.in_id = 8'(img[p]);
        @(negedge clk); chk("ready_wload", bus.in_ready_o, 0);
        @(posedge clk); #1;
        w_load_iv = 1'b0; bus.in_iv = 1'b0;
      end
      send_pixel(img[p], p / 8, p % 8, gaps ? int'($urandom_range(0, 2)) : 0);
      if (p == 0) chk("busy_stream", busy_o, 1);
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.in_ready_o) n++;
      else break;
    end
    chk("drain_len", n, 2);
    chk("busy_idle", busy_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[6];
    int   ident[9], wv[9];
    int   wcur;
    tbl[0] = '{20,    1, 2, 2, 0,   46};
    tbl[1] = '{127, 127, 0, 0, 0,  127};
    tbl[2] = '{127, -128, 0, 0, 1,   0};
    tbl[3] = '{127, -128, 0, 0, 0, -128};
    tbl[4] = '{3,     1, 0, 0, 0,   27};
    tbl[5] = '{3,     1, 0, 1, 0,   14};

    nrst = 1'b0; w_load_iv = 1'b0; w_addr_id = 4'd0; w_data_id = 8'sd0;
    bias_id = 24'sd0; cfg_relu_i = 1'b0; cfg_shift_i = 5'd0;
    bus.in_iv = 1'b0; bus.in_id = 8'sd0;
    for (int i = 0; i < 9; i++) begin wm[i] = 0; ident[i] = (i == 4) ? 1 : 0; end
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_ready", bus.in_ready_o, 1);
    chk("reset_ov", bus.out_ov, 0);
    chk("reset_od", bus.out_od, 0);
    chk("reset_last", bus.out_last_o, 0);
    chk("reset_busy", busy_o, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Ramp image, identity kernel: plain, with gaps + ignored weight write, then again unreloaded.
    for (int p = 0; p < 64; p++) img[p] = p;
    use_model = 1'b1;
    load_w(ident);
    run_frame(1'b0, -1, -1);
    run_frame(1'b1, 30, -1);
    run_frame(1'b0, -1, -1);
    // Abort mid-frame; cleared weights give zeros; reloaded identity restores the ramp result.
    run_frame(1'b0, -1, 30);
    run_frame(1'b0, -1, -1);
    load_w(ident);
    run_frame(1'b0, -1, -1);

    wcur = 1000;
    use_model = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].wt != wcur) begin
        for (int i = 0; i < 9; i++) wv[i] = tbl[t].wt;
        load_w(wv);
        wcur = tbl[t].wt;
      end
      for (int p = 0; p < 64; p++) img[p] = tbl[t].pix;
      bias_g = tbl[t].bias; shift_g = tbl[t].shift; relu_g = tbl[t].relu;
      exp_const = tbl[t].expv;
      run_frame(1'b0, -1, -1);
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/conv_layer_stream.md
Name: conv_layer_stream

Overview:
Parametrised streaming 2-D convolution layer for the one-chan DNN datapath. It replaces the fixed hard-wired conv stages. It accepts one grid pixel per cycle in raster order and buffers K-1 rows in line buffers. Each valid KxK window (no padding) is MAC'd against runtime-loaded weights, bias is added, and the result is requantised with rounding shift, optional ReLU and saturation. Instances chain back-to-back to build conv stacks that feed the classifier.

Parameters:
DATA_WIDTH, 8, signed pixel/weight/output width
ROW_NUM, 8, input grid rows
COL_NUM, 8, input grid columns
K, 3, kernel size (KxK); 1 <= K <= min(ROW_NUM, COL_NUM)
ACC_WIDTH, 24, signed accumulator/bias width; must be >= 2*DATA_WIDTH + clog2(K*K)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
w_load_iv  in  1  weight write strobe
w_addr_id  in  clog2(K*K)  weight index, row-major (r*K+c)
w_data_id  in  DATA_WIDTH  signed weight
bias_id  in  ACC_WIDTH  signed bias, sampled at frame start
cfg_relu_i  in  1  1 = clamp negatives to 0, sampled at frame start
cfg_shift_i  in  5  requant right-shift, sampled at frame start
in_iv  in  1  pixel valid
in_id  in  DATA_WIDTH  signed pixel
in_ready_o  out  1  pixel accepted when in_iv & in_ready_o
out_ov  out  1  result valid, one-cycle pulse per result
out_od  out  DATA_WIDTH  signed result
out_last_o  out  1  high with final result of frame
busy_o  out  1  high in STREAM or DRAIN

Behaviour:
- Reset applies asynchronously on nrst low. State goes to IDLE. Weights, bias/cfg registers, line buffers, counters and pipeline all clear to 0. Outputs: in_ready_o=1, out_ov=0, out_od=0, out_last_o=0, busy_o=0. A reset mid-frame aborts the frame, and no further out_ov appears.
- FSM states are IDLE, STREAM and DRAIN.
  - IDLE → STREAM on the first accepted pixel. bias_id, cfg_relu_i and cfg_shift_i are latched on that edge.
  - STREAM → DRAIN on acceptance of pixel ROW_NUM*COL_NUM-1.
  - DRAIN → IDLE after 2 cycles, once the pipeline is empty.
- in_ready_o = (state != DRAIN) && !w_load_iv. Pixels may arrive with arbitrary in_iv gaps; results are gap-independent.
- Weight writes take effect only in IDLE. w_load_iv in STREAM or DRAIN is ignored, and the weights stay unchanged for the frame. A load and a pixel in the same IDLE cycle performs the load; the pixel is not accepted.
- Row and column counters wrap at COL_NUM and ROW_NUM. Line buffers hold K-1 rows of COL_NUM pixels. A window register holds a KxK array.
- A window is valid when the accepted pixel has r >= K-1 and c >= K-1. Output count is (ROW_NUM-K+1)*(COL_NUM-K+1), in raster order.
- Latency: out_ov is high in the cycle after the 2nd rising edge following the accepting edge. The pipeline has 2 stages:
  - Stage 1: products and adder tree.
  - Stage 2: bias add and requant.
- No output back-pressure; the consumer must always accept.
- Arithmetic:
  - acc = sum(w[i][j]*x[i][j]) + bias, signed, ACC_WIDTH, no wrap given the parameter rule.
  - If shift > 0: acc = (acc + (1 << (shift-1))) >>> shift (arithmetic). If shift = 0: no rounding.
  - If relu and acc < 0: acc = 0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- out_last_o is asserted only with the result of the last window. out_od holds its last value when out_ov=0.
- K=1 degenerates to a per-pixel scale/bias/requant with the same latency and no line buffer.

Test Plan:
1. Identity kernel: centre weight 1, others 0, bias 0, shift 0. Input pixel = r*8+c (0..63).
   - 36 outputs: 9..14, 17..22, …, 49..54.
   - First out_ov 2 cycles after pixel 18 is accepted.
   - out_last_o is set with value 54.
2. All-ones kernel, input all 20, bias 2, shift 2: (180+2+2)>>>2 = 46, for all 36 outputs.
3. Saturation with all weights 127 and input 127, shift 0 → 127. Negative case with weights -128, input 127:
   - ReLU=1 → 0.
   - ReLU=0 → -128.
4. Repeat scenario 1 with random in_iv gaps and a w_load_iv pulse mid-frame. Outputs must be identical, and the weights unchanged afterwards.
5. Reset mid-frame, after 30 pixels:
   - All outputs return to reset values immediately and weights clear to 0.
   - A new frame with a reloaded identity kernel yields scenario 1 results.
6. Back-to-back frames with a different cfg_shift_i (0 then 1) and input all 3, all-ones kernel:
   - Frame 1 gives 27.
   - Frame 2 gives (27+1)>>>1 = 14.
   - in_ready_o is low for exactly 2 DRAIN cycles between frames.
